sync_fifo: RTL and testbench

// - Single-clock synchronous FIFO buffering a byte stream between a producer and a consumer.
// - Datapath utility block: writer side uses wr_en/data_in/full; reader side uses rd_en/data_out/empty.
// - Registered read data; full/empty flags are derived from extended read/write pointers.

---
 rtl/sync_fifo.sv | 103 ++++++++++
 tb/tb_sync_fifo.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO: registered read data, flags from extended read/write pointers.
// Define FIFO_STATUS_EN to add count/overflow/underflow status outputs.
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  empty,
   output logic                  full
`ifdef FIFO_STATUS_EN
   ,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
`endif
);

   localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   // Handshake: a write is taken on a rising edge when wr_en & (~full | rd_en);
   // a read is taken when rd_en & ~empty, and data_out carries it after that edge.
   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
   logic                  wr_accept, rd_accept;

   always_comb begin
      wr_addr   = wr_ptr_q[ADDR_WIDTH-1:0];
      rd_addr   = rd_ptr_q[ADDR_WIDTH-1:0];
      empty     = (wr_ptr_q == rd_ptr_q);
      full      = (wr_addr == rd_addr) & (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
      // When full, a concurrent read frees the slot the write lands in.
      wr_accept = wr_en & (~full | rd_en);
      rd_accept = rd_en & ~empty;
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      data_out_d = data_out_q;
      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_accept) begin
         rd_ptr_d   = rd_ptr_q + PTR_ONE;
         data_out_d = mem[rd_addr];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         data_out_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         data_out_q <= data_out_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_addr] <= data_in;
      end
   end

   assign data_out = data_out_q;

`ifdef FIFO_STATUS_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   always_comb begin
      overflow_d  = wr_en & full & ~rd_en;
      underflow_d = rd_en & empty;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign count     = wr_ptr_q - rd_ptr_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a queue of accepted writes is popped and compared as reads complete,
// with flags (and status outputs under FIFO_STATUS_EN) checked after every edge.
module tb_sync_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk;
   logic          rst;
   logic          wr_en;
   logic          rd_en;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;
   logic          empty;
   logic          full;
`ifdef FIFO_STATUS_EN
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;
`endif

   sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .data_in  (data_in),
      .data_out (data_out),
      .empty    (empty),
      .full     (full)
`ifdef FIFO_STATUS_EN
      ,
      .count    (count),
      .overflow (overflow),
      .underflow(underflow)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] last_data;
   int            n_total;
   int            n_bad;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_total++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_outputs(input logic exp_ov, input logic exp_uf);
      check("data_out", 32'(data_out), 32'(last_data));
      check("empty", 32'(empty), 32'(exp_q.size() == 0));
      check("full", 32'(full), 32'(exp_q.size() == DEPTH));
`ifdef FIFO_STATUS_EN
      check("count", 32'(count), 32'(exp_q.size()));
      check("overflow", 32'(overflow), 32'(exp_ov));
      check("underflow", 32'(underflow), 32'(exp_uf));
`else
      if (exp_ov && exp_uf) n_total += 0;
`endif
   endtask

   // driver: one clock with the given requests; model updated from pre-edge occupancy
   task automatic drive_cycle(input logic w, input logic r, input logic [DW-1:0] d);
      bit m_full, m_empty, wa, ra, ov, uf;
      wr_en   = w;
      rd_en   = r;
      data_in = d;
      m_full  = (exp_q.size() == DEPTH);
      m_empty = (exp_q.size() == 0);
      wa = w && (!m_full || r);
      ra = r && !m_empty;
      ov = w && m_full && !r;
      uf = r && m_empty;
      @(posedge clk);
      #1;
      if (ra) last_data = exp_q.pop_front();
      if (wa) exp_q.push_back(d);
      check_outputs(ov, uf);
   endtask

   initial begin
      logic [DW-1:0] b;
      bit            tog;
      n_total   = 0;
      n_bad     = 0;
      last_data = '0;
      rst       = 1'b1;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      data_in   = '0;

      // asynchronous reset with requests pending, before any clock edge
      #1;
      rst   = 1'b0;
      wr_en = 1'b1;
      rd_en = 1'b1;
      data_in = 8'hEE;
      #1;
      check_outputs(1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check_outputs(1'b0, 1'b0);
      @(negedge clk);
      rst   = 1'b1;
      wr_en = 1'b0;
      rd_en = 1'b0;

      // fill, then writes while full are dropped
      for (int i = 1; i <= DEPTH; i++) drive_cycle(1'b1, 1'b0, DW'(i));
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, 8'hAA);

      // drain, then one read while empty
      for (int i = 0; i < DEPTH; i++) drive_cycle(1'b0, 1'b1, 8'h00);
      check("drain_last", 32'(data_out), 32'h10);
      drive_cycle(1'b0, 1'b1, 8'h00);
      check("read_empty_hold", 32'(data_out), 32'h10);

      // concurrent write/read while empty: only the write is taken
      drive_cycle(1'b1, 1'b1, 8'h3C);
      drive_cycle(1'b0, 1'b1, 8'h00);
      check("conc_empty_read", 32'(data_out), 32'h3C);

      // concurrent write/read while full
      for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 1'b0, DW'($urandom_range(0, 255)));
      drive_cycle(1'b1, 1'b1, 8'h55);
      check("conc_full_flag", 32'(full), 32'h1);
      for (int i = 0; i < DEPTH; i++) drive_cycle(1'b0, 1'b1, 8'h00);
      check("conc_full_last", 32'(data_out), 32'h55);

      // stream of 40 random bytes with rd_en toggling; an extra read every two bytes keeps occupancy bounded
      tog = 1'b1;
      for (int i = 0; i < 40; i++) begin
         b = DW'($urandom_range(0, 255));
         drive_cycle(1'b1, tog, b);
         tog = ~tog;
         if (i[0]) drive_cycle(1'b0, 1'b1, 8'h00);
      end
      while (exp_q.size() != 0) drive_cycle(1'b0, 1'b1, 8'h00);

      // reset mid-burst, between clock edges
      for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0, DW'(8'h60 + i));
      rd_en = 1'b1;
      rst   = 1'b0;
      #1;
      exp_q.delete();
      last_data = '0;
      check_outputs(1'b0, 1'b0);
      @(negedge clk);
      rst   = 1'b1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      drive_cycle(1'b1, 1'b0, 8'h99);
      drive_cycle(1'b0, 1'b1, 8'h00);
      check("post_reset_read", 32'(data_out), 32'h99);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
